term_writer: RTL and testbench

Parametrised character-stream terminal engine: accepts bytes from the UART receiver, tracks the cursor, writes printable glyphs into the `vga_text_mode` text buffer and drives its blit port for scroll and clear. It sits between `uart_rx` and `vga_text_mode` in `top`, replacing the inline cursor/scroll logic with a handshaked, size-generic block.

---
 rtl/term_writer.sv | 193 +++++++++++++++++++
 tb/tb_term_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_writer.sv
// Character-stream terminal engine: decodes received bytes, tracks the cursor, writes glyphs
// and drives scroll/clear blits. Define TERM_WRITER_ESC_EN to enable the ESC 'c' full-screen clear.
module term_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11,
    parameter int TAB    = 8
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              blit_en,
    output logic [ADDR_W-1:0] blit_start,
    output logic [ADDR_W-1:0] blit_end,
    output logic [7:0]        blit_offset,
    input  logic              blit_complete,
    output logic [5:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] SCREEN_END = ADDR_W'(ROWS * COLS);
    localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW   = 6'(ROWS - 1);
    localparam logic [7:0]        TAB_MASK   = 8'(TAB - 1);
    localparam logic [7:0]        SCROLL_OFS = 8'(COLS);

    typedef enum logic [3:0] {
        IDLE, WRITE, SCROLL, SCROLL_WAIT, CLEAR, CLEAR_WAIT, ESC_SEEN, RIS, RIS_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        row_q, row_d;
    logic [6:0]        col_q, col_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] blit_start_q, blit_start_d;
    logic [ADDR_W-1:0] blit_end_q, blit_end_d;
    logic [7:0]        blit_offset_q, blit_offset_d;
    logic              scroll_pend_q, scroll_pend_d;

    logic [ADDR_W-1:0] row_base;
    logic [7:0]        tab_col;

    assign row_base = ADDR_W'(row_q) * COLS_A;
    assign tab_col  = ({1'b0, col_q} | TAB_MASK) + 8'd1;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        blit_start_d  = blit_start_q;
        blit_end_d    = blit_end_q;
        blit_offset_d = blit_offset_q;
        scroll_pend_d = scroll_pend_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        wr_addr_d = row_base + ADDR_W'(col_q);
                        wr_data_d = rx_data;
                        state_d   = WRITE;
                        if (col_q == LAST_COL) begin
                            col_d = 7'd0;
                            // Wrapping off the bottom row defers the scroll until the glyph is written.
                            if (row_q == LAST_ROW) scroll_pend_d = 1'b1;
                            else                   row_d = row_q + 6'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (rx_data)
                            8'h0A: begin
                                if (row_q == LAST_ROW) begin
                                    state_d       = SCROLL;
                                    blit_start_d  = '0;
                                    blit_end_d    = LAST_BASE;
                                    blit_offset_d = SCROLL_OFS;
                                end else begin
                                    row_d = row_q + 6'd1;
                                end
                            end
                            8'h0D: col_d = 7'd0;
                            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
                            8'h09: col_d = (tab_col >= {1'b0, LAST_COL}) ? LAST_COL : tab_col[6:0];
`ifdef TERM_WRITER_ESC_EN
                            8'h1B: state_d = ESC_SEEN;
`endif
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (scroll_pend_q) begin
                    scroll_pend_d = 1'b0;
                    state_d       = SCROLL;
                    blit_start_d  = '0;
                    blit_end_d    = LAST_BASE;
                    blit_offset_d = SCROLL_OFS;
                end else begin
                    state_d = IDLE;
                end
            end
            SCROLL:      state_d = SCROLL_WAIT;
            SCROLL_WAIT: begin
                if (blit_complete) begin
                    state_d       = CLEAR;
                    blit_start_d  = LAST_BASE;
                    blit_end_d    = SCREEN_END;
                    blit_offset_d = 8'd0;
                end
            end
            CLEAR:       state_d = CLEAR_WAIT;
            CLEAR_WAIT:  if (blit_complete) state_d = IDLE;
`ifdef TERM_WRITER_ESC_EN
            ESC_SEEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'h63) begin
                        state_d       = RIS;
                        blit_start_d  = '0;
                        blit_end_d    = SCREEN_END;
                        blit_offset_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RIS:         state_d = RIS_WAIT;
            RIS_WAIT: begin
                if (blit_complete) begin
                    state_d = IDLE;
                    row_d   = 6'd0;
                    col_d   = 7'd0;
                end
            end
`endif
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            blit_start_q  <= '0;
            blit_end_q    <= '0;
            blit_offset_q <= '0;
            scroll_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            blit_start_q  <= blit_start_d;
            blit_end_q    <= blit_end_d;
            blit_offset_q <= blit_offset_d;
            scroll_pend_q <= scroll_pend_d;
        end
    end

`ifdef TERM_WRITER_ESC_EN
    assign rx_ready = (state_q == IDLE) || (state_q == ESC_SEEN);
    assign blit_en  = (state_q == SCROLL) || (state_q == CLEAR) || (state_q == RIS);
`else
    assign rx_ready = (state_q == IDLE);
    assign blit_en  = (state_q == SCROLL) || (state_q == CLEAR);
`endif
    assign busy        = (state_q != IDLE);
    assign wr_en       = (state_q == WRITE);
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign blit_start  = blit_start_q;
    assign blit_end    = blit_end_q;
    assign blit_offset = blit_offset_q;
    assign cur_row     = row_q;
    assign cur_col     = col_q;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: transaction-level model (cursor + expected write/blit queues) checked every cycle.
module tb_term_writer;

    localparam int COLS = 80, ROWS = 25, ADDR_W = 11, TAB = 8;

    logic              clk100 = 1'b0;
    logic              rst_n  = 1'b0;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              blit_en;
    logic [ADDR_W-1:0] blit_start, blit_end;
    logic [7:0]        blit_offset;
    logic              blit_complete;
    logic [5:0]        cur_row;
    logic [6:0]        cur_col;
    logic              busy;

    always #5 clk100 = ~clk100;

    term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .TAB(TAB)) dut (
        .clk100(clk100), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blit_en(blit_en), .blit_start(blit_start), .blit_end(blit_end),
        .blit_offset(blit_offset), .blit_complete(blit_complete),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    int errors = 0, checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { int a; int d; } wr_t;
    typedef struct { int s; int e; int o; bit ris; } bl_t;
    wr_t wq[$];
    bl_t bq[$];
    bl_t cur_bl;
    int  m_row, m_col, owed;
    bit  esc_pend;
    int  log_wa[$], log_wd[$];
    bl_t log_bl[$];

    function automatic void model_reset();
        wq.delete(); bq.delete();
        m_row = 0; m_col = 0; owed = 0; esc_pend = 0;
        cur_bl = '{0, 0, 0, 1'b0};
    endfunction

    function automatic void clear_logs();
        log_wa.delete(); log_wd.delete(); log_bl.delete();
    endfunction

    function automatic void model_accept(int b);
`ifdef TERM_WRITER_ESC_EN
        if (esc_pend) begin
            esc_pend = 0;
            if (b == 8'h63) bq.push_back('{0, ROWS * COLS, 0, 1'b1});
            return;
        end
        if (b == 8'h1B) begin
            esc_pend = 1;
            return;
        end
`endif
        if (b >= 8'h20 && b <= 8'h7E) begin
            wq.push_back('{m_row * COLS + m_col, b});
            m_col++;
            if (m_col == COLS) begin m_col = 0; m_row++; end
        end else if (b == 8'h0A) m_row++;
        else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h08) m_col = (m_col > 0) ? m_col - 1 : 0;
        else if (b == 8'h09) begin
            m_col = (m_col | (TAB - 1)) + 1;
            if (m_col > COLS - 1) m_col = COLS - 1;
        end
        if (m_row == ROWS) begin
            m_row = ROWS - 1;
            bq.push_back('{0, (ROWS - 1) * COLS, COLS, 1'b0});
            bq.push_back('{(ROWS - 1) * COLS, ROWS * COLS, 0, 1'b0});
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk100) begin
        bit  exp_ready;
        wr_t w;
        bl_t b;
        if (rst_n) begin
            exp_ready = (wq.size() == 0) && (bq.size() == 0) && (owed == 0);
            chk("rx_ready", rx_ready, exp_ready);
            chk("busy", busy, !exp_ready || esc_pend);
            chk("wr_en", wr_en, wq.size() > 0);
            chk("blit_en", blit_en, (wq.size() == 0) && (bq.size() > 0) && (owed == 0));
            if (wr_en && wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", wr_addr, w.a);
                chk("wr_data", wr_data, w.d);
                log_wa.push_back(int'(wr_addr));
                log_wd.push_back(int'(wr_data));
            end
            if (blit_en && bq.size() > 0 && owed == 0 && wq.size() == 0) begin
                b = bq.pop_front();
                chk("blit_start", blit_start, b.s);
                chk("blit_end", blit_end, b.e);
                chk("blit_offset", blit_offset, b.o);
                log_bl.push_back('{int'(blit_start), int'(blit_end), int'(blit_offset), b.ris});
                cur_bl = b;
                owed   = 1;
            end else if (owed > 0) begin
                chk("blit_start_hold", blit_start, cur_bl.s);
                chk("blit_end_hold", blit_end, cur_bl.e);
                chk("blit_offset_hold", blit_offset, cur_bl.o);
            end
            chk("cur_row", cur_row, m_row);
            chk("cur_col", cur_col, m_col);
        end
    end

    // ---------------- blit responder ----------------
    bit auto_resp = 1'b1;
    bit resp_real = 1'b0;
    int dly = 0;

    always @(posedge clk100) begin
        if (auto_resp) begin
            if (blit_complete && resp_real && owed > 0) begin
                owed = 0;
                if (cur_bl.ris) begin m_row = 0; m_col = 0; end
            end
            #1;
            blit_complete = 1'b0;
            resp_real     = 1'b0;
            if (owed > 0) begin
                if (dly == 0) begin
                    blit_complete = 1'b1;
                    resp_real     = 1'b1;
                    dly = $urandom_range(0, 4);
                end else dly--;
            end else if (wq.size() == 0 && bq.size() == 0 && !esc_pend &&
                         $urandom_range(0, 15) == 0) begin
                blit_complete = 1'b1;  // stray pulse that the DUT must ignore
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int cyc);
        bit acc;
        rx_data  = b;
        rx_valid = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk100);
            acc = rx_ready;
            @(posedge clk100);
            cyc++;
            if (acc) begin model_accept(int'(b)); break; end
            if (cyc > 300) begin
                checks++; errors++;
                $display("FAIL accept_timeout: byte %0d not accepted within 300 cycles", b);
                break;
            end
        end
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wq.size() != 0 || bq.size() != 0 || owed != 0 || rx_ready !== 1'b1) && n < 500) begin
            step(1);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL idle_timeout: DUT not idle after 500 cycles");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r;
        logic [7:0] bt;
        rx_valid = 1'b0; rx_data = 8'h00; blit_complete = 1'b0;
        model_reset();
        step(3);
        chk("rst_rx_ready", rx_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);       chk("rst_blit_en", blit_en, 0);
        chk("rst_wr_addr", wr_addr, 0);   chk("rst_wr_data", wr_data, 0);
        chk("rst_blit_start", blit_start, 0); chk("rst_blit_end", blit_end, 0);
        chk("rst_blit_offset", blit_offset, 0);
        chk("rst_cur_row", cur_row, 0);   chk("rst_cur_col", cur_col, 0);
        rst_n = 1'b1;
        step(1);

        // "AB" from home
        clear_logs();
        send(8'h41, c); send(8'h42, c);
        chk("ab_byte_spacing", c, 2);
        step(2);
        chk("ab_writes", log_wa.size(), 2);
        if (log_wa.size() == 2) begin
            chk("ab_addr0", log_wa[0], 0); chk("ab_data0", log_wd[0], 8'h41);
            chk("ab_addr1", log_wa[1], 1); chk("ab_data1", log_wd[1], 8'h42);
        end
        chk("ab_row", cur_row, 0); chk("ab_col", cur_col, 2);

        // to (3,79) with back-to-back control bytes, then wrap
        send(8'h0D, c);
        for (int i = 0; i < 3; i++) begin send(8'h0A, c); chk("lf_b2b", c, 1); end
        for (int i = 0; i < 10; i++) begin send(8'h09, c); chk("tab_b2b", c, 1); end
        chk("pos_row", cur_row, 3); chk("pos_col", cur_col, 79);
        clear_logs();
        send(8'h58, c); step(2);
        chk("wrap_writes", log_wa.size(), 1);
        if (log_wa.size() == 1) chk("wrap_addr", log_wa[0], 319);
        chk("wrap_row", cur_row, 4); chk("wrap_col", cur_col, 0);
        chk("model_wrap_row", m_row, 4);

        // tab / backspace / CR
        send(8'h09, c); send(8'h08, c); send(8'h08, c); send(8'h08, c);
        chk("setup_col5", cur_col, 5);
        clear_logs();
        send(8'h09, c); chk("tab_col8", cur_col, 8);
        send(8'h08, c); chk("bs_col7", cur_col, 7);
        send(8'h0D, c); chk("cr_col0", cur_col, 0);
        send(8'h08, c); chk("bs_sat0", cur_col, 0);
        step(1);
        chk("ctrl_no_writes", log_wa.size(), 0);

        // scroll from (24,10)
        for (int i = 0; i < 20; i++) send(8'h0A, c);
        send(8'h09, c); send(8'h61, c); send(8'h62, c);
        wait_idle();
        chk("pre_scroll_row", cur_row, 24); chk("pre_scroll_col", cur_col, 10);
        clear_logs();
        send(8'h0A, c);
        wait_idle();
        chk("scroll_blits", log_bl.size(), 2);
        if (log_bl.size() == 2) begin
            chk("scroll_s", log_bl[0].s, 0);    chk("scroll_e", log_bl[0].e, 1920);
            chk("scroll_o", log_bl[0].o, 80);
            chk("clear_s", log_bl[1].s, 1920);  chk("clear_e", log_bl[1].e, 2000);
            chk("clear_o", log_bl[1].o, 0);
        end
        chk("post_scroll_row", cur_row, 24); chk("post_scroll_col", cur_col, 10);
        chk("model_scroll_col", m_col, 10);

        // reset while waiting for the scroll blit
        auto_resp = 1'b0;
        step(1);
        blit_complete = 1'b0;
        send(8'h0A, c);
        r = 0;
        while (owed == 0 && r < 20) begin step(1); r++; end
        chk("reached_scroll_wait", owed, 1);
        step(2);
        rst_n = 1'b0;
        model_reset();
        step(1);
        rst_n = 1'b1;
        clear_logs();
        step(2);
        blit_complete = 1'b1;
        step(1);
        blit_complete = 1'b0;
        step(4);
        chk("rr_no_blit", log_bl.size(), 0);
        chk("rr_rx_ready", rx_ready, 1); chk("rr_busy", busy, 0);
        chk("rr_blit_en", blit_en, 0);   chk("rr_wr_en", wr_en, 0);
        chk("rr_blit_start", blit_start, 0); chk("rr_blit_end", blit_end, 0);
        chk("rr_blit_offset", blit_offset, 0);
        chk("rr_wr_addr", wr_addr, 0);   chk("rr_wr_data", wr_data, 0);
        chk("rr_row", cur_row, 0);       chk("rr_col", cur_col, 0);
        auto_resp = 1'b1;

`ifdef TERM_WRITER_ESC_EN
        for (int i = 0; i < 7; i++) send(8'h0A, c);
        for (int i = 0; i < 7; i++) send(8'h41, c);
        wait_idle();
        chk("esc_pre_row", cur_row, 7); chk("esc_pre_col", cur_col, 7);
        clear_logs();
        send(8'h1B, c); send(8'h63, c);
        wait_idle();
        chk("ris_blits", log_bl.size(), 1);
        if (log_bl.size() == 1) begin
            chk("ris_s", log_bl[0].s, 0); chk("ris_e", log_bl[0].e, 2000);
            chk("ris_o", log_bl[0].o, 0);
        end
        chk("ris_row", cur_row, 0); chk("ris_col", cur_col, 0);
`else
        clear_logs();
        send(8'h1B, c); chk("esc_ignored_b2b", c, 1);
        send(8'h5A, c); step(2);
        chk("esc_next_writes", log_wd.size(), 1);
        if (log_wd.size() == 1) begin
            chk("esc_next_data", log_wd[0], 8'h5A); chk("esc_next_addr", log_wa[0], 0);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      bt = 8'($urandom_range(32, 126));
            else if (r < 66) bt = 8'h0A;
            else if (r < 73) bt = 8'h0D;
            else if (r < 80) bt = 8'h08;
            else if (r < 87) bt = 8'h09;
            else             bt = 8'($urandom_range(0, 255));
            send(bt, c);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
        end
        wait_idle();
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
